// File: rtl/craps_pkg.sv
// -----------------------------------------------------------------------------
// craps_pkg
// Shared types and constants for the craps game controller.
//   state_t    : game FSM state; encodings are visible on state_out
//                (00 COMEOUT, 01 POINT, 10 WIN, 11 LOSE)
//   SUM_W      : width of the dice sum / point registers
//   SUM_*      : sums that decide the come-out roll
//   DIE_MIN/MAX: legal die face range
// -----------------------------------------------------------------------------
package craps_pkg;

    typedef enum logic [1:0] {
        ST_COMEOUT = 2'b00,
        ST_POINT   = 2'b01,
        ST_WIN     = 2'b10,
        ST_LOSE    = 2'b11
    } state_t;

    localparam int unsigned SUM_W = 4;

    localparam logic [SUM_W-1:0] SUM_SEVEN  = 4'd7;
    localparam logic [SUM_W-1:0] SUM_ELEVEN = 4'd11;
    localparam logic [SUM_W-1:0] CRAPS_2    = 4'd2;
    localparam logic [SUM_W-1:0] CRAPS_3    = 4'd3;
    localparam logic [SUM_W-1:0] CRAPS_12   = 4'd12;

    localparam logic [2:0] DIE_MIN = 3'd1;
    localparam logic [2:0] DIE_MAX = 3'd6;

endpackage

// File: rtl/roll_edge_sync.sv
// -----------------------------------------------------------------------------
// roll_edge_sync
// Synchronises the asynchronous roll button and emits a one-cycle strobe on
// each rising edge. The strobe is registered, so it appears SYNC_STAGES+1
// clocks after the button edge. A held button produces a single strobe.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   roll     : raw button level (asynchronous)
//   roll_evt : one-cycle strobe per press
// -----------------------------------------------------------------------------
module roll_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic roll,
    output logic roll_evt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_evt  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], roll};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_evt  <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign roll_evt = r_evt;

endmodule

// File: rtl/craps_game_ctrl.sv
// -----------------------------------------------------------------------------
// craps_game_ctrl
// Plays one game of craps per sequence of roll presses: come-out roll, point
// phase, win/lose, then the next press starts a new game.
// Configuration macro: CRAPS_STATS_EN builds the win/loss tally registers;
// without it win_count/loss_count are constant 0.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   roll            : raw roll button (asynchronous)
//   dice1, dice2    : die values from the roller, legal 1..6
//   state_out       : current game state
//   sum, point      : last accepted sum, established point (0 = none)
//   win, lose       : high while in WIN / LOSE
//   reroll          : one-cycle pulse when a press was rejected
//   roll_count      : accepted rolls in this game (saturating)
//   win_count       : games won since reset (saturating)
//   loss_count      : games lost since reset (saturating)
// -----------------------------------------------------------------------------
module craps_game_ctrl
    import craps_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             roll,
    input  logic [2:0]       dice1,
    input  logic [2:0]       dice2,
    output logic [1:0]       state_out,
    output logic [SUM_W-1:0] sum,
    output logic [SUM_W-1:0] point,
    output logic             win,
    output logic             lose,
    output logic             reroll,
    output logic [CNT_W-1:0] roll_count,
    output logic [CNT_W-1:0] win_count,
    output logic [CNT_W-1:0] loss_count
);

    state_t           r_state, w_state_nxt;
    logic [SUM_W-1:0] r_sum, w_sum_nxt;
    logic [SUM_W-1:0] r_point, w_point_nxt;
    logic [CNT_W-1:0] r_roll_cnt, w_roll_cnt_nxt;
    logic             r_reroll, w_reroll_nxt;

    logic             w_roll_evt;
    logic [SUM_W-1:0] w_dice_sum;
    logic             w_dice_ok;

    roll_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .roll     (roll),
        .roll_evt (w_roll_evt)
    );

    assign w_dice_sum = {1'b0, dice1} + {1'b0, dice2};
    assign w_dice_ok  = (dice1 >= DIE_MIN) && (dice1 <= DIE_MAX) &&
                        (dice2 >= DIE_MIN) && (dice2 <= DIE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_COMEOUT;
            r_sum      <= '0;
            r_point    <= '0;
            r_roll_cnt <= '0;
            r_reroll   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sum      <= w_sum_nxt;
            r_point    <= w_point_nxt;
            r_roll_cnt <= w_roll_cnt_nxt;
            r_reroll   <= w_reroll_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sum_nxt      = r_sum;
        w_point_nxt    = r_point;
        w_roll_cnt_nxt = r_roll_cnt;
        w_reroll_nxt   = 1'b0;

        if (w_roll_evt) begin
            if (r_state == ST_WIN || r_state == ST_LOSE) begin
                // New game: dice are ignored, sum is kept for display.
                w_state_nxt    = ST_COMEOUT;
                w_point_nxt    = '0;
                w_roll_cnt_nxt = '0;
            end else if (!w_dice_ok) begin
                w_reroll_nxt = 1'b1;
            end else begin
                w_sum_nxt = w_dice_sum;
                if (r_roll_cnt != '1) w_roll_cnt_nxt = r_roll_cnt + 1'b1;
                if (r_state == ST_COMEOUT) begin
                    if (w_dice_sum == SUM_SEVEN || w_dice_sum == SUM_ELEVEN)
                        w_state_nxt = ST_WIN;
                    else if (w_dice_sum == CRAPS_2 || w_dice_sum == CRAPS_3 ||
                             w_dice_sum == CRAPS_12)
                        w_state_nxt = ST_LOSE;
                    else begin
                        w_point_nxt = w_dice_sum;
                        w_state_nxt = ST_POINT;
                    end
                end else begin
                    if (w_dice_sum == r_point)
                        w_state_nxt = ST_WIN;
                    else if (w_dice_sum == SUM_SEVEN)
                        w_state_nxt = ST_LOSE;
                end
            end
        end
    end

`ifdef CRAPS_STATS_EN
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_loss_cnt;
    logic             w_enter_win;
    logic             w_enter_lose;

    assign w_enter_win  = (w_state_nxt == ST_WIN)  && (r_state != ST_WIN);
    assign w_enter_lose = (w_state_nxt == ST_LOSE) && (r_state != ST_LOSE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_cnt  <= '0;
            r_loss_cnt <= '0;
        end else begin
            if (w_enter_win && r_win_cnt != '1)   r_win_cnt  <= r_win_cnt + 1'b1;
            if (w_enter_lose && r_loss_cnt != '1) r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign win_count  = r_win_cnt;
    assign loss_count = r_loss_cnt;
`else
    assign win_count  = '0;
    assign loss_count = '0;
`endif

    assign state_out  = r_state;
    assign sum        = r_sum;
    assign point      = r_point;
    assign win        = (r_state == ST_WIN);
    assign lose       = (r_state == ST_LOSE);
    assign reroll     = r_reroll;
    assign roll_count = r_roll_cnt;

endmodule

// File: tb/tb_craps_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_craps_game_ctrl
// Directed table of game sequences, randomized presses checked against a
// rule-level craps model, plus hold, saturation and async-reset sequences.
// Honours CRAPS_STATS_EN for the expected tally values.
// -----------------------------------------------------------------------------
module tb_craps_game_ctrl;

    localparam int SYNC = 2;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          roll = 1'b0;
    logic [2:0]    dice1 = 3'd0;
    logic [2:0]    dice2 = 3'd0;
    logic [1:0]    state_out;
    logic [3:0]    sum, point;
    logic          win, lose, reroll;
    logic [CW-1:0] roll_count, win_count, loss_count;

    craps_game_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .roll       (roll),
        .dice1      (dice1),
        .dice2      (dice2),
        .state_out  (state_out),
        .sum        (sum),
        .point      (point),
        .win        (win),
        .lose       (lose),
        .reroll     (reroll),
        .roll_count (roll_count),
        .win_count  (win_count),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int last_rr  = 0;

    // Rule-level model: game outcome (0 playing, 1 won, 2 lost), point, etc.
    int m_over, m_point, m_sum, m_rolls, m_wins, m_losses, m_rr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int stats(input int v);
`ifdef CRAPS_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_over = 0; m_point = 0; m_sum = 0; m_rolls = 0;
        m_wins = 0; m_losses = 0; m_rr = 0;
    endtask

    task automatic model_press(input int d1, input int d2);
        int s;
        m_rr = 0;
        if (m_over != 0) begin
            m_over = 0; m_point = 0; m_rolls = 0;
        end else if (d1 < 1 || d1 > 6 || d2 < 1 || d2 > 6) begin
            m_rr = 1;
        end else begin
            s = d1 + d2;
            m_sum = s;
            if (m_rolls < CMAX) m_rolls++;
            if (m_point == 0) begin
                if (s == 7 || s == 11)                 m_over = 1;
                else if (s == 2 || s == 3 || s == 12)  m_over = 2;
                else                                   m_point = s;
            end else if (s == m_point) m_over = 1;
            else if (s == 7)           m_over = 2;
            if (m_over == 1 && m_wins < CMAX)   m_wins++;
            if (m_over == 2 && m_losses < CMAX) m_losses++;
        end
    endtask

    function automatic int model_state();
        if (m_over == 1) return 2;
        if (m_over == 2) return 3;
        return (m_point != 0) ? 1 : 0;
    endfunction

    // Press and release the button; counts reroll-high cycles seen.
    task automatic press(input int d1, input int d2, input int hold);
        int rr;
        rr = 0;
        dice1 = 3'(d1);
        dice2 = 3'(d2);
        @(negedge clk);
        roll = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (reroll) rr++;
        end
        roll = 1'b0;
        for (int i = 0; i < SYNC + 4; i++) begin
            @(negedge clk);
            if (reroll) rr++;
        end
        last_rr = rr;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"},  int'(state_out),  model_state());
        check({tag, ".sum"},    int'(sum),        m_sum);
        check({tag, ".point"},  int'(point),      m_point);
        check({tag, ".rolls"},  int'(roll_count), m_rolls);
        check({tag, ".reroll"}, last_rr,          m_rr);
        check({tag, ".win"},    int'(win),        (m_over == 1) ? 1 : 0);
        check({tag, ".lose"},   int'(lose),       (m_over == 2) ? 1 : 0);
        check({tag, ".wins"},   int'(win_count),  stats(m_wins));
        check({tag, ".losses"}, int'(loss_count), stats(m_losses));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        roll = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    typedef struct {
        int d1, d2, st, sm, pt, rc, rr, w, l;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // d1 d2 | state sum point rolls reroll wins losses
        vecs[0]  = '{3, 4, 2,  7, 0, 1, 0, 1, 0};
        vecs[1]  = '{5, 5, 0,  7, 0, 0, 0, 1, 0};
        vecs[2]  = '{1, 1, 3,  2, 0, 1, 0, 1, 1};
        vecs[3]  = '{2, 3, 0,  2, 0, 0, 0, 1, 1};
        vecs[4]  = '{6, 6, 3, 12, 0, 1, 0, 1, 2};
        vecs[5]  = '{1, 1, 0, 12, 0, 0, 0, 1, 2};
        vecs[6]  = '{2, 2, 1,  4, 4, 1, 0, 1, 2};
        vecs[7]  = '{3, 2, 1,  5, 4, 2, 0, 1, 2};
        vecs[8]  = '{1, 3, 2,  4, 4, 3, 0, 2, 2};
        vecs[9]  = '{6, 6, 0,  4, 0, 0, 0, 2, 2};
        vecs[10] = '{4, 4, 1,  8, 8, 1, 0, 2, 2};
        vecs[11] = '{0, 3, 1,  8, 8, 1, 1, 2, 2};
        vecs[12] = '{3, 7, 1,  8, 8, 1, 1, 2, 2};
        vecs[13] = '{5, 2, 3,  7, 8, 2, 0, 2, 3};
        vecs[14] = '{7, 7, 0,  7, 0, 0, 0, 2, 3};

        model_reset();
        do_reset();
        check("reset.state",  int'(state_out),  0);
        check("reset.sum",    int'(sum),        0);
        check("reset.point",  int'(point),      0);
        check("reset.rolls",  int'(roll_count), 0);
        check("reset.flags",  int'({win, lose, reroll}), 0);
        check("reset.tally",  int'(win_count) + int'(loss_count), 0);

        // Directed game sequences
        for (int i = 0; i < 15; i++) begin
            press(vecs[i].d1, vecs[i].d2, SYNC + 4);
            model_press(vecs[i].d1, vecs[i].d2);
            check($sformatf("vec%0d.state", i),  int'(state_out),  vecs[i].st);
            check($sformatf("vec%0d.sum", i),    int'(sum),        vecs[i].sm);
            check($sformatf("vec%0d.point", i),  int'(point),      vecs[i].pt);
            check($sformatf("vec%0d.rolls", i),  int'(roll_count), vecs[i].rc);
            check($sformatf("vec%0d.reroll", i), last_rr,          vecs[i].rr);
            check($sformatf("vec%0d.wins", i),   int'(win_count),  stats(vecs[i].w));
            check($sformatf("vec%0d.losses", i), int'(loss_count), stats(vecs[i].l));
        end

        // Randomized presses against the model; illegal faces appear ~1 in 4
        for (int i = 0; i < 200; i++) begin
            int a, b;
            a = $urandom_range(0, 7);
            b = $urandom_range(0, 7);
            press(a, b, SYNC + 2 + $urandom_range(0, 6));
            model_press(a, b);
            check_model($sformatf("rnd%0d", i));
        end

        // Long hold: one evaluation only (a second eval would change state)
        do_reset();
        press(2, 2, 100);
        model_press(2, 2);
        check_model("hold");
        check("hold.point", int'(point), 4);
        check("hold.rolls", int'(roll_count), 1);

        // Saturation: point 4 then 255 more non-deciding rolls
        for (int i = 0; i < CMAX; i++) begin
            press(2, 3, SYNC + 3);
            model_press(2, 3);
        end
        check_model("sat");
        check("sat.rolls", int'(roll_count), CMAX);
        check("sat.state", int'(state_out), 1);

        // Async reset mid-POINT with point 6
        do_reset();
        press(3, 3, SYNC + 4);
        model_press(3, 3);
        press(4, 1, SYNC + 4);
        model_press(4, 1);
        check("pre_rst.point", int'(point), 6);
        check("pre_rst.rolls", int'(roll_count), 2);
        #3;
        rst = 1'b0;
        #1;
        check("arst.state", int'(state_out),  0);
        check("arst.point", int'(point),      0);
        check("arst.rolls", int'(roll_count), 0);
        check("arst.sum",   int'(sum),        0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        last_rr = 0;
        check_model("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
